// File: rtl/demux_1_4_2_bit_reg_v.sv
// Registered 1-to-4 distributor for CODE_W-bit codes with a valid/ready handshake.
// A code goes to the lane picked by the auto pointer or by i_sel_code. A one-cycle DONE state marks each full frame.
module demux_1_4_2_bit_reg_v #(
  parameter int CODE_W = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [CODE_W-1:0] i_code,
  input  logic [1:0]        i_sel_code,
  input  logic              i_auto,
  input  logic              i_clr,
  output logic [CODE_W-1:0] o_code_0,
  output logic [CODE_W-1:0] o_code_1,
  output logic [CODE_W-1:0] o_code_2,
  output logic [CODE_W-1:0] o_code_3,
  output logic [3:0]        o_lane_vld,
  output logic [1:0]        o_ptr,
  output logic              o_frame_done
);

  typedef enum logic {
    FILL = 1'b0,
    DONE = 1'b1
  } state_e;

  state_e                       state_q, state_d;
  logic [3:0][CODE_W-1:0]       lane_q, lane_d;
  logic [3:0]                   vld_q, vld_d;
  logic [1:0]                   ptr_q, ptr_d;
  logic                         accept;
  logic [1:0]                   tgtLane;
  logic [3:0]                   vldNext;

  assign accept  = (state_q == FILL) && i_en && i_valid && !i_clr;
  assign tgtLane = i_auto ? ptr_q : i_sel_code;
  assign vldNext = vld_q | (4'b0001 << tgtLane);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= FILL;
      lane_q  <= '0;
      vld_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      vld_q   <= vld_d;
      ptr_q   <= ptr_d;
    end
  end

  // Lanes keep their data across DONE -> FILL so the downstream mux sees a stable frame.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    vld_d   = vld_q;
    ptr_d   = ptr_q;
    if (state_q == DONE) begin
      state_d = FILL;
      vld_d   = '0;
      ptr_d   = '0;
      if (i_clr) begin
        lane_d = '0;
      end
    end else if (i_clr) begin
      lane_d = '0;
      vld_d  = '0;
      ptr_d  = '0;
    end else if (accept) begin
      lane_d[tgtLane] = i_code;
      vld_d           = vldNext;
      if (i_auto) begin
        ptr_d = ptr_q + 2'd1;
      end
      if (vldNext == 4'hF) begin
        state_d = DONE;
      end
    end
  end

  assign o_ready      = (state_q == FILL);
  assign o_frame_done = (state_q == DONE);
  assign o_code_0     = lane_q[0];
  assign o_code_1     = lane_q[1];
  assign o_code_2     = lane_q[2];
  assign o_code_3     = lane_q[3];
  assign o_lane_vld   = vld_q;
  assign o_ptr        = ptr_q;

endmodule

// File: tb/tb_demux_1_4_2_bit_reg_v.sv
// Directed self-checking bench for demux_1_4_2_bit_reg_v.
// Lane outputs are packed as {lane3, lane2, lane1, lane0} for compact checks.
module tb_demux_1_4_2_bit_reg_v;

  logic       clk = 1'b0;
  logic       rst, en, valid, ready, autoMode, clr, frameDone;
  logic [1:0] code, selCode, ptr;
  logic [1:0] code0, code1, code2, code3;
  logic [3:0] laneVld;
  logic [7:0] lanesAll;
  int         compareCount  = 0;
  int         mismatchCount = 0;

  always #5 clk = ~clk;

  demux_1_4_2_bit_reg_v #(.CODE_W(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_valid(valid), .o_ready(ready),
    .i_code(code), .i_sel_code(selCode), .i_auto(autoMode), .i_clr(clr),
    .o_code_0(code0), .o_code_1(code1), .o_code_2(code2), .o_code_3(code3),
    .o_lane_vld(laneVld), .o_ptr(ptr), .o_frame_done(frameDone)
  );

  assign lanesAll = {code3, code2, code1, code0};

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then let the edge happen and settle 1 ns past it.
  task automatic applyStimulus(input logic r, input logic e, input logic v, input logic [1:0] c,
                               input logic [1:0] s, input logic a, input logic cl);
    rst = r; en = e; valid = v; code = c; selCode = s; autoMode = a; clr = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0);
  endtask

  task automatic autoWrite(input logic [1:0] c);
    applyStimulus(1'b0, 1'b1, 1'b1, c, 2'd0, 1'b1, 1'b0);
  endtask

  task automatic manualWrite(input logic [1:0] s, input logic [1:0] c);
    applyStimulus(1'b0, 1'b1, 1'b1, c, s, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd3, 2'd1, 1'b1, 1'b0);
    checkOutput("rst_ready", ready, 1);
    checkOutput("rst_done", frameDone, 0);
    checkOutput("rst_vld", laneVld, 4'h0);
    checkOutput("rst_ptr", ptr, 0);
    checkOutput("rst_lanes", lanesAll, 8'h00);

    // Auto fill 3,2,1,0
    autoWrite(2'd3);
    checkOutput("t1_vld1", laneVld, 4'b0001);
    checkOutput("t1_lane0", lanesAll, 8'h03);
    checkOutput("t1_ptr1", ptr, 1);
    autoWrite(2'd2);
    checkOutput("t1_vld2", laneVld, 4'b0011);
    autoWrite(2'd1);
    checkOutput("t1_vld3", laneVld, 4'b0111);
    checkOutput("t1_done_early", frameDone, 0);
    autoWrite(2'd0);
    checkOutput("t1_vld4", laneVld, 4'b1111);
    checkOutput("t1_done", frameDone, 1);
    checkOutput("t1_ready_done", ready, 0);
    checkOutput("t1_lanes", lanesAll, 8'h1B);
    idle();
    checkOutput("t1_done_end", frameDone, 0);
    checkOutput("t1_ready_end", ready, 1);
    checkOutput("t1_vld_end", laneVld, 4'h0);
    checkOutput("t1_ptr_end", ptr, 0);
    checkOutput("t1_lanes_hold", lanesAll, 8'h1B);

    // Manual out-of-order with overwrite
    manualWrite(2'd2, 2'd1);
    checkOutput("t2_vld_a", laneVld, 4'b0100);
    manualWrite(2'd2, 2'd3);
    checkOutput("t2_vld_b", laneVld, 4'b0100);
    checkOutput("t2_lanes_b", lanesAll, 8'h3B);
    manualWrite(2'd0, 2'd2);
    checkOutput("t2_lanes_c", lanesAll, 8'h3A);
    manualWrite(2'd3, 2'd1);
    checkOutput("t2_vld_d", laneVld, 4'b1101);
    checkOutput("t2_done_d", frameDone, 0);
    checkOutput("t2_ptr_d", ptr, 0);
    manualWrite(2'd1, 2'd0);
    checkOutput("t2_done_e", frameDone, 1);
    checkOutput("t2_lanes_e", lanesAll, 8'h72);
    checkOutput("t2_ptr_e", ptr, 0);
    idle();

    // Enable low mid-frame, then valid held through DONE
    autoWrite(2'd1);
    checkOutput("t3_vld_a", laneVld, 4'b0001);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd3, 2'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd3, 2'd0, 1'b1, 1'b0);
    checkOutput("t3_en_vld", laneVld, 4'b0001);
    checkOutput("t3_en_ptr", ptr, 1);
    checkOutput("t3_en_lanes", lanesAll, 8'h71);
    autoWrite(2'd2);
    autoWrite(2'd3);
    checkOutput("t3_ptr_c", ptr, 3);
    autoWrite(2'd0);
    checkOutput("t3_done", frameDone, 1);
    checkOutput("t3_lanes", lanesAll, 8'h39);
    autoWrite(2'd2);
    checkOutput("t3_held_vld", laneVld, 4'h0);
    checkOutput("t3_held_lanes", lanesAll, 8'h39);
    checkOutput("t3_held_ready", ready, 1);
    autoWrite(2'd2);
    checkOutput("t3_acc_vld", laneVld, 4'b0001);
    checkOutput("t3_acc_lanes", lanesAll, 8'h3A);
    checkOutput("t3_acc_ptr", ptr, 1);

    // Clear mid-frame with a valid code, then clear during DONE
    autoWrite(2'd1);
    checkOutput("t4_lanes_a", lanesAll, 8'h36);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'd3, 2'd0, 1'b1, 1'b1);
    checkOutput("t4_clr_lanes", lanesAll, 8'h00);
    checkOutput("t4_clr_vld", laneVld, 4'h0);
    checkOutput("t4_clr_ptr", ptr, 0);
    checkOutput("t4_clr_ready", ready, 1);
    for (int i = 0; i < 4; i++) autoWrite(2'd1);
    checkOutput("t4_done", frameDone, 1);
    checkOutput("t4_lanes_full", lanesAll, 8'h55);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1);
    checkOutput("t4_dclr_done", frameDone, 0);
    checkOutput("t4_dclr_lanes", lanesAll, 8'h00);
    checkOutput("t4_dclr_vld", laneVld, 4'h0);

    // Reset mid-frame
    for (int i = 0; i < 3; i++) autoWrite(2'd2);
    checkOutput("t5_vld", laneVld, 4'b0111);
    checkOutput("t5_lanes", lanesAll, 8'h2A);
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd1, 2'd0, 1'b1, 1'b0);
    checkOutput("t5_rst_lanes", lanesAll, 8'h00);
    checkOutput("t5_rst_vld", laneVld, 4'h0);
    checkOutput("t5_rst_ptr", ptr, 0);
    checkOutput("t5_rst_ready", ready, 1);
    for (int i = 0; i < 4; i++) autoWrite(2'(i));
    checkOutput("t5_done", frameDone, 1);
    checkOutput("t5_lanes_full", lanesAll, 8'hE4);
    idle();

    // Mixed mode: pointer reaches 3 and wraps on completion, single pulse
    autoWrite(2'd1);
    autoWrite(2'd2);
    manualWrite(2'd3, 2'd3);
    checkOutput("t6_vld", laneVld, 4'b1011);
    checkOutput("t6_ptr", ptr, 2);
    checkOutput("t6_done_early", frameDone, 0);
    autoWrite(2'd0);
    checkOutput("t6_ptr3", ptr, 3);
    checkOutput("t6_done", frameDone, 1);
    checkOutput("t6_lanes", lanesAll, 8'hC9);
    idle();
    checkOutput("t6_ptr_wrap", ptr, 0);
    checkOutput("t6_done_once", frameDone, 0);
    idle();
    checkOutput("t6_done_none", frameDone, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/demux_1_4_2_bit_reg_v.md
Name: demux_1_4_2_bit_reg_v

Overview:
- Registered 1-to-4 distributor for 2-bit codes; the inverse of the 4:1 2-bit code multiplexer.
- Accepts a stream of codes with a valid/ready handshake and steers each accepted code into one of four output lane registers.
- Lane selection is either explicit (i_sel_code) or by an auto-advancing pointer.
- Flags frame completion when all four lanes hold fresh data, so a downstream 4:1 mux stage can consume the lanes as one frame.

Parameters:
CODE_W  2  width of each code / lane register

Ports:
i_clk         input   1       rising-edge clock
i_rst         input   1       synchronous reset, active-high
i_en          input   1       enable; low blocks acceptance of new codes
i_valid       input   1       i_code is valid this cycle
o_ready       output  1       block can accept a code this cycle
i_code        input   CODE_W  code to distribute
i_sel_code    input   2       target lane when i_auto=0
i_auto        input   1       1: target lane = o_ptr; 0: target lane = i_sel_code
i_clr         input   1       clear the current frame (lanes, flags, pointer)
o_code_0      output  CODE_W  lane 0 register
o_code_1      output  CODE_W  lane 1 register
o_code_2      output  CODE_W  lane 2 register
o_code_3      output  CODE_W  lane 3 register
o_lane_vld    output  4       per-lane written-this-frame flags, bit n = lane n
o_ptr         output  2       auto-mode lane pointer
o_frame_done  output  1       one-cycle pulse: frame complete

Behaviour:
- Reset (i_rst=1 at a clock edge) sets:
  - o_code_0..3 = 0, o_lane_vld = 0, o_ptr = 0, o_frame_done = 0.
  - State = FILL, so o_ready = 1 from the first cycle after reset.
  - Reset overrides all other inputs in any state, mid-frame included.
- State machine, two states:
  - FILL: o_ready = 1, o_frame_done = 0.
  - DONE: o_ready = 0, o_frame_done = 1. Lasts exactly one cycle, then returns to FILL with o_lane_vld = 0 and o_ptr = 0.
- Accept condition: state==FILL & i_en & i_valid & !i_clr.
- On accept, target lane L = i_auto ? o_ptr : i_sel_code. At the next edge:
  - o_code_L <= i_code.
  - o_lane_vld[L] <= 1.
  - If i_auto=1, o_ptr <= o_ptr+1, wrapping 3 -> 0.
  - If i_auto=0, o_ptr is unchanged.
- Write latency: 1 cycle; the lane output updates the cycle after accept.
- Completion: if the accept makes o_lane_vld all ones, the next state is DONE. o_frame_done rises in the same cycle the 4th lane's data appears. FILL-to-FILL frame throughput is 5 cycles minimum.
- Rewriting an already-valid lane (manual mode, or a mixed auto/manual pointer collision):
  - The code is overwritten and the flag stays 1.
  - Completion is unaffected; it requires all 4 distinct lanes.
- i_en=0: no accepts; o_ptr, the flags and the lanes hold. A DONE already entered still completes its single cycle (i_en does not stretch DONE).
- i_clr (priority: i_rst > i_clr > accept):
  - FILL: next cycle o_lane_vld = 0, o_ptr = 0, o_code_0..3 = 0. Any simultaneous valid code is dropped (not accepted).
  - DONE: o_frame_done still pulses this cycle. Next cycle is FILL with lanes, flags and pointer cleared.
- Lane registers are not cleared on the DONE -> FILL transition. They hold the previous frame until overwritten or cleared, so the downstream mux sees stable data.
- i_valid while o_ready=0 (DONE): the code is not accepted. The source must hold it until o_ready=1.
- Width: i_code is stored unmodified, with no truncation or extension. o_ptr arithmetic is modulo 4.

Test Plan:
1. Auto fill: reset; i_auto=1, i_en=1, i_valid=1 for 4 cycles with codes 3,2,1,0 -> o_code_0..3 = 3,2,1,0; o_lane_vld steps 0001, 0011, 0111, 1111; o_frame_done=1 and o_ready=0 for exactly the cycle after the 4th accept; then o_ptr=0, o_lane_vld=0, lanes still 3,2,1,0.
2. Manual out-of-order with overwrite: i_auto=0, writes (sel,code) = (2,1), (2,3), (0,2), (3,1), (1,0) -> no done pulse after the 4th write (flags 1101); done after the 5th; lanes = 2,0,3,1; o_ptr stays 0 throughout.
3. Backpressure/enable: toggle i_en low for 2 cycles mid-frame with i_valid=1 -> no lane, flag or pointer change during those cycles. During DONE, hold i_valid=1 with code 2 -> not accepted; it is accepted into lane 0 in the first FILL cycle.
4. Clear: after 2 auto accepts, assert i_clr together with i_valid=1, code 3 -> next cycle all lanes 0, flags 0, o_ptr=0, and code 3 is not written. i_clr during DONE -> pulse still seen, lanes zero afterwards.
5. Reset mid-frame: after 3 accepts assert i_rst with i_valid=1 -> all outputs 0 next cycle, o_ready=1. A full frame afterwards completes normally.
6. Pointer wrap with mixed mode: auto writes to lanes 0 and 1, manual write to lane 3, then auto writes -> pointer wrap 3 -> 0 without duplicate completion; done only when lane 2 written.
